// File: rtl/xadac_wtrack.sv
// Write-channel tracker between a vector-store unit and an AXI master port.
// It bounds outstanding AW bursts, holds W until its AW is issued, and flags bad or spurious B responses.
module xadac_wtrack #(
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 128,
    parameter int MaxOut    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IdWidth-1:0]         s_aw_id,
    input  logic [AddrWidth-1:0]       s_aw_addr,
    input  logic                       s_aw_valid,
    output logic                       s_aw_ready,
    input  logic [DataWidth-1:0]       s_w_data,
    input  logic [DataWidth/8-1:0]     s_w_strb,
    input  logic                       s_w_valid,
    output logic                       s_w_ready,
    output logic [IdWidth-1:0]         m_aw_id,
    output logic [AddrWidth-1:0]       m_aw_addr,
    output logic                       m_aw_valid,
    input  logic                       m_aw_ready,
    output logic [DataWidth-1:0]       m_w_data,
    output logic [DataWidth/8-1:0]     m_w_strb,
    output logic                       m_w_valid,
    input  logic                       m_w_ready,
    input  logic [IdWidth-1:0]         m_b_id,
    input  logic [1:0]                 m_b_resp,
    input  logic                       m_b_valid,
    output logic                       m_b_ready,
    input  logic                       fence,
    output logic                       idle,
    output logic [$clog2(MaxOut):0]    outstanding,
    output logic                       err,
    output logic [IdWidth-1:0]         err_id,
    input  logic                       err_clr
);

    localparam int CntW = $clog2(MaxOut) + 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOut);
    localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
    localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};

    logic [CntW-1:0]    out_cnt_r;
    logic [CntW-1:0]    w_owed_r;
    logic               err_r;
    logic [IdWidth-1:0] err_id_r;

    logic aw_en_s;
    logic aw_hs_s;
    logic w_en_s;
    logic w_hs_s;
    logic b_hs_s;
    logic b_dec_s;
    logic new_err_s;

    // Handshake qualifiers; everything is gated off while reset is asserted.
    always_comb begin
        aw_en_s   = ~rst & ~fence & (out_cnt_r < MaxCnt);
        aw_hs_s   = s_aw_valid & m_aw_ready & aw_en_s;
        w_en_s    = ~rst & ((w_owed_r != CntZero) | aw_hs_s);
        w_hs_s    = s_w_valid & m_w_ready & w_en_s;
        b_hs_s    = m_b_valid & ~rst;
        b_dec_s   = b_hs_s & (out_cnt_r != CntZero);
        new_err_s = b_hs_s & ((out_cnt_r == CntZero) | (m_b_resp != 2'b00));
    end

    assign m_aw_id     = s_aw_id;
    assign m_aw_addr   = s_aw_addr;
    assign m_aw_valid  = s_aw_valid & aw_en_s;
    assign s_aw_ready  = m_aw_ready & aw_en_s;
    assign m_w_data    = s_w_data;
    assign m_w_strb    = s_w_strb;
    assign m_w_valid   = s_w_valid & w_en_s;
    assign s_w_ready   = m_w_ready & w_en_s;
    assign m_b_ready   = ~rst;
    assign idle        = (out_cnt_r == CntZero) & (w_owed_r == CntZero);
    assign outstanding = out_cnt_r;
    assign err         = err_r;
    assign err_id      = err_id_r;

    // Outstanding-burst counter; a B with nothing outstanding never decrements.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_r <= CntZero;
        end else begin
            case ({aw_hs_s, b_dec_s})
                2'b10:   out_cnt_r <= out_cnt_r + CntOne;
                2'b01:   out_cnt_r <= out_cnt_r - CntOne;
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

    // W beats owed to issued AWs; a lone W handshake implies w_owed_r > 0, so no underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_owed_r <= CntZero;
        end else begin
            case ({aw_hs_s, w_hs_s})
                2'b10: begin
                    if (w_owed_r < MaxCnt) begin
                        w_owed_r <= w_owed_r + CntOne;
                    end else begin
                        w_owed_r <= w_owed_r;
                    end
                end
                2'b01:   w_owed_r <= w_owed_r - CntOne;
                default: w_owed_r <= w_owed_r;
            endcase
        end
    end

    // Sticky error: first error ID wins, and a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r    <= 1'b0;
            err_id_r <= {IdWidth{1'b0}};
        end else if (new_err_s) begin
            err_r <= 1'b1;
            if (!err_r || err_clr) begin
                err_id_r <= m_b_id;
            end else begin
                err_id_r <= err_id_r;
            end
        end else if (err_clr) begin
            err_r    <= 1'b0;
            err_id_r <= {IdWidth{1'b0}};
        end else begin
            err_r    <= err_r;
            err_id_r <= err_id_r;
        end
    end

endmodule

// File: tb/tb_xadac_wtrack.sv
// Directed bench for xadac_wtrack: a cycle-by-cycle vector table plus hand-written
// sequences for the full-window, reset and pass-through cases.
module tb_xadac_wtrack;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   s_aw_id;
    logic [63:0]  s_aw_addr;
    logic         s_aw_valid;
    logic         s_aw_ready;
    logic [127:0] s_w_data;
    logic [15:0]  s_w_strb;
    logic         s_w_valid;
    logic         s_w_ready;
    logic [3:0]   m_aw_id;
    logic [63:0]  m_aw_addr;
    logic         m_aw_valid;
    logic         m_aw_ready;
    logic [127:0] m_w_data;
    logic [15:0]  m_w_strb;
    logic         m_w_valid;
    logic         m_w_ready;
    logic [3:0]   m_b_id;
    logic [1:0]   m_b_resp;
    logic         m_b_valid;
    logic         m_b_ready;
    logic         fence;
    logic         idle;
    logic [3:0]   outstanding;
    logic         err;
    logic [3:0]   err_id;
    logic         err_clr;

    int checks = 0;
    int errors = 0;

    xadac_wtrack dut (
        .clk(clk), .rst(rst),
        .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .fence(fence), .idle(idle), .outstanding(outstanding),
        .err(err), .err_id(err_id), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       awv;
        logic       wv;
        logic       bv;
        logic [1:0] resp;
        logic [3:0] bid;
        logic       fnc;
        logic       clr;
        logic       e_awr;
        logic       e_wr;
        logic       e_idle;
        logic [3:0] e_out;
        logic       e_err;
        logic [3:0] e_eid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic awv, input logic wv, input logic bv,
                                input logic [1:0] resp, input logic [3:0] bid,
                                input logic fnc, input logic clr,
                                input logic e_awr, input logic e_wr, input logic e_idle,
                                input logic [3:0] e_out, input logic e_err, input logic [3:0] e_eid);
        vec_t v;
        v.awv = awv; v.wv = wv; v.bv = bv; v.resp = resp; v.bid = bid;
        v.fnc = fnc; v.clr = clr; v.e_awr = e_awr; v.e_wr = e_wr; v.e_idle = e_idle;
        v.e_out = e_out; v.e_err = e_err; v.e_eid = e_eid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        s_aw_valid = 1'b0; s_w_valid = 1'b0; m_b_valid = 1'b0;
        m_b_resp = 2'b00; m_b_id = 4'd0; fence = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        s_aw_id = 4'd0; s_aw_addr = 64'd0; s_w_data = 128'd0; s_w_strb = 16'd0;
        m_aw_ready = 1'b1; m_w_ready = 1'b1;

        //                awv   wv    bv    resp   bid   fnc   clr   awr   wr    idle  out   err   eid
        // W waits three cycles for its AW
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        // AW first, W one cycle later through w_owed
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0));
        // build up to three, then AW and B together
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0));
        // fence with two outstanding, drain, then release
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0));
        // SLVERR id 5 then DECERR id 9: first error wins, then clear
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd3, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 4'd5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        // spurious B id 3 at zero outstanding
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd3));
        // clear racing a new error: new error wins and its ID replaces the old one
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd3));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd7));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd7));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0));

        // reset holds both forward valids and b_ready low
        @(negedge clk);
        s_aw_valid = 1'b1; s_w_valid = 1'b1;
        #1;
        chk("rst_m_aw_valid", m_aw_valid, 1'b0);
        chk("rst_m_w_valid", m_w_valid, 1'b0);
        chk("rst_m_b_ready", m_b_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet();
        #1;
        chk("rst_outstanding", outstanding, 4'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_err_id", err_id, 4'd0);
        chk("rst_m_b_ready_after", m_b_ready, 1'b1);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            s_aw_valid = vecs[i].awv; s_w_valid = vecs[i].wv; m_b_valid = vecs[i].bv;
            m_b_resp = vecs[i].resp; m_b_id = vecs[i].bid; fence = vecs[i].fnc; err_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_s_aw_ready", i), s_aw_ready, vecs[i].e_awr);
            chk($sformatf("v%0d_m_aw_valid", i), m_aw_valid, vecs[i].awv & vecs[i].e_awr);
            chk($sformatf("v%0d_s_w_ready", i), s_w_ready, vecs[i].e_wr);
            chk($sformatf("v%0d_m_w_valid", i), m_w_valid, vecs[i].wv & vecs[i].e_wr);
            chk($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
            chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
            chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
            chk($sformatf("v%0d_err_id", i), err_id, vecs[i].e_eid);
            @(posedge clk);
        end

        // eight back-to-back AW+W, checking pass-through of id/addr/data/strb
        for (int i = 0; i < 8; i++) begin
            logic [63:0]  a;
            logic [127:0] d;
            logic [15:0]  s;
            @(negedge clk);
            quiet();
            a = {$urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            s = 16'($urandom);
            s_aw_id = 4'(i); s_aw_addr = a; s_w_data = d; s_w_strb = s;
            s_aw_valid = 1'b1; s_w_valid = 1'b1;
            #1;
            chk($sformatf("full%0d_s_aw_ready", i), s_aw_ready, 1'b1);
            chk($sformatf("full%0d_outstanding", i), outstanding, 4'(i));
            chk($sformatf("full%0d_m_aw_id", i), m_aw_id, 4'(i));
            chk($sformatf("full%0d_m_aw_addr", i), m_aw_addr, a);
            chk($sformatf("full%0d_m_w_data", i), m_w_data, d);
            chk($sformatf("full%0d_m_w_strb", i), m_w_strb, s);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk("full_outstanding8", outstanding, 4'd8);
        chk("full_s_aw_ready", s_aw_ready, 1'b0);
        chk("full_m_aw_valid", m_aw_valid, 1'b0);
        chk("full_s_w_ready", s_w_ready, 1'b0);
        chk("full_idle", idle, 1'b0);
        @(posedge clk);
        @(negedge clk);
        m_b_valid = 1'b1; m_b_resp = 2'b00; m_b_id = 4'd0;
        #1;
        chk("full_b_cycle_s_aw_ready", s_aw_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        m_b_valid = 1'b0;
        #1;
        chk("full_after_b_outstanding", outstanding, 4'd7);
        chk("full_after_b_s_aw_ready", s_aw_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        quiet();
        #1;
        chk("full_refill_outstanding", outstanding, 4'd8);
        chk("full_refill_err", err, 1'b0);
        @(posedge clk);

        // reset mid-operation, then a late B is treated as spurious
        @(negedge clk);
        rst = 1'b1; s_aw_valid = 1'b1; s_w_valid = 1'b1; m_b_valid = 1'b1; m_b_id = 4'd6;
        #1;
        chk("midrst_m_aw_valid", m_aw_valid, 1'b0);
        chk("midrst_m_w_valid", m_w_valid, 1'b0);
        chk("midrst_m_b_ready", m_b_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet();
        #1;
        chk("midrst_outstanding", outstanding, 4'd0);
        chk("midrst_idle", idle, 1'b1);
        m_b_valid = 1'b1; m_b_id = 4'd6;
        @(posedge clk);
        @(negedge clk);
        quiet();
        #1;
        chk("late_b_outstanding", outstanding, 4'd0);
        chk("late_b_err", err, 1'b1);
        chk("late_b_err_id", err_id, 4'd6);
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
